// File: rtl/func_gen_pkg.sv
// Shared types and constants for the function-generator segment sequencer.
package func_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fgs_state_t;

  localparam logic [2:0] IDLE_SEL   = 3'b011;
  localparam logic [2:0] SEL_SINE   = 3'd0;
  localparam logic [2:0] SEL_SQUARE = 3'd1;
  localparam logic [2:0] SEL_COUNT  = 3'd3;

  localparam int unsigned FGS_DUR_W = 8;

  typedef struct packed {
    logic [2:0]           sel;
    logic [FGS_DUR_W-1:0] dur;
  } fgs_seg_t;

endpackage

// File: rtl/func_gen_sequencer_seg_mem.sv
// Segment slot register file: one synchronous write, one asynchronous read,
// synchronous clear of every slot to {IDLE_SEL, duration 1}.
module fgs_seg_mem
  import func_gen_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned DUR_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned W     = 3 + DUR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  localparam logic [W-1:0] RST_WORD = {IDLE_SEL, DUR_W'(1)};

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= RST_WORD;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/func_gen_sequencer.sv
// Plays a programmed list of {sel, duration} segments into the function generator.
// Define FGS_LOOP_EN to add the loop input (wrap to slot 0 after last_idx).
module func_gen_sequencer
  import func_gen_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned DUR_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2:0]       wr_sel,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [AW-1:0]    last_idx,
  input  logic             start,
  input  logic             stop,
`ifdef FGS_LOOP_EN
  input  logic             loop,
`endif
  output logic [2:0]       sel_out,
  output logic             gen_rst,
  output logic             busy,
  output logic [AW-1:0]    seg_idx,
  output logic             done
);

  fgs_state_t       state_q, state_d;
  logic [2:0]       sel_out_q, sel_out_d;
  logic             gen_rst_q, gen_rst_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    seg_idx_q, seg_idx_d;
  logic             done_q, done_d;
  logic [AW-1:0]    last_q, last_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;

  logic             mem_we;
  logic [2+DUR_W:0] rd_data;
  logic [2:0]       rd_sel;
  logic [DUR_W-1:0] rd_dur;
  logic             loop_active;

`ifdef FGS_LOOP_EN
  assign loop_active = loop;
`else
  assign loop_active = 1'b0;
`endif

  assign mem_we = wr_en && (state_q == IDLE);
  assign rd_sel = rd_data[2+DUR_W -: 3];
  assign rd_dur = rd_data[DUR_W-1:0];

  // Read port follows the next slot index so sel_out can be registered on entry to LOAD.
  fgs_seg_mem #(
    .DEPTH(DEPTH),
    .DUR_W(DUR_W)
  ) u_seg_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (mem_we),
    .wr_addr(wr_addr),
    .wr_data({wr_sel, wr_dur}),
    .rd_addr(seg_idx_d),
    .rd_data(rd_data)
  );

  always_comb begin
    state_d   = state_q;
    seg_idx_d = seg_idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          last_d    = last_idx;
          seg_idx_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q > DUR_W'(1)) begin
          cnt_d = cnt_q - DUR_W'(1);
        end else if (seg_idx_q != last_q) begin
          seg_idx_d = seg_idx_q + 1'b1;
          state_d   = LOAD;
        end else if (loop_active) begin
          seg_idx_d = '0;
          state_d   = LOAD;
        end else begin
          seg_idx_d = '0;
          state_d   = IDLE;
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop && (state_q != IDLE)) begin
      state_d   = IDLE;
      seg_idx_d = '0;
      done_d    = 1'b0;
    end

    // A write to the slot being started lands at the same edge, so forward it.
    sel_out_d = sel_out_q;
    if (state_d == IDLE) begin
      sel_out_d = IDLE_SEL;
    end else if (state_d == LOAD) begin
      sel_out_d = (mem_we && (wr_addr == seg_idx_d)) ? wr_sel : rd_sel;
    end
    gen_rst_d = (state_d == LOAD);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_out_q <= IDLE_SEL;
      gen_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      seg_idx_q <= '0;
      done_q    <= 1'b0;
      last_q    <= '0;
      cnt_q     <= DUR_W'(1);
    end else begin
      state_q   <= state_d;
      sel_out_q <= sel_out_d;
      gen_rst_q <= gen_rst_d;
      busy_q    <= busy_d;
      seg_idx_q <= seg_idx_d;
      done_q    <= done_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel_out = sel_out_q;
  assign gen_rst = gen_rst_q;
  assign busy    = busy_q;
  assign seg_idx = seg_idx_q;
  assign done    = done_q;

endmodule

// File: doc/func_gen_sequencer.md
# func_gen_sequencer

Plays a programmed list of waveform segments on the digital function generator. Each segment is a waveform select code and a duration. The block drives the generator's `sel` input and pulses its phase-restart input at every segment boundary. It sits between the control/register side and the function generator; the generator's datapath stays unchanged.

## Interface
- `DEPTH`, 8: number of segment slots (power of two, 2..16); `AW = $clog2(DEPTH)`
- `DUR_W`, 8: width of the per-segment duration field
- `clk`  in  1: system clock, rising edge
- `rst`  in  1: synchronous, active-low reset
- `wr_en`  in  1: write one segment slot (accepted only in IDLE)
- `wr_addr`  in  AW: slot index to write
- `wr_sel`  in  3: waveform select code stored in the slot
- `wr_dur`  in  DUR_W: segment duration in RUN cycles
- `last_idx`  in  AW: index of the last slot to play; sampled on accepted `start`
- `start`  in  1: begin playback at slot 0 (accepted only in IDLE)
- `stop`  in  1: abort playback
- `loop`  in  1: restart at slot 0 after `last_idx` (present only with `FGS_LOOP_EN`)
- `sel_out`  out  3: select code to the generator
- `gen_rst`  out  1: active-high phase-restart pulse to the generator
- `busy`  out  1: high in LOAD or RUN
- `seg_idx`  out  AW: slot currently playing
- `done`  out  1: one-cycle pulse on natural completion

## Operation
- States: IDLE, LOAD, RUN.
- **IDLE**
  - `sel_out` = `IDLE_SEL` (3'b011, count/sawtooth); `busy` = 0.
  - `wr_en` writes `{wr_sel, wr_dur}` into slot `wr_addr`.
  - `start` & !`stop`: latch `last_idx`, set `seg_idx` = 0, go to LOAD.
- **LOAD** (1 cycle)
  - `sel_out` = slot[`seg_idx`].sel; `gen_rst` = 1.
  - Load the duration counter with max(dur, 1); dur = 0 is played as 1.
  - Go to RUN.
- **RUN**
  - `sel_out` holds the slot sel; `gen_rst` = 0; counter decrements each cycle.
  - On the cycle the counter equals 1:
    - `seg_idx` ≠ latched last: `seg_idx`+1, go to LOAD.
    - `seg_idx` = last and loop active: `seg_idx` = 0, go to LOAD.
    - Otherwise: go to IDLE and pulse `done`.
- `stop` in LOAD or RUN: go to IDLE next cycle; no `done` pulse; `seg_idx` resets to 0.
- `stop` in IDLE has no effect and blocks a simultaneous `start`.
- `wr_en` and `start` outside IDLE are ignored. A slot write takes effect in the next IDLE cycle.
- `start` and `wr_en` in the same IDLE cycle: the write completes, and playback reads the new value if it hits slot 0.
- `last_idx` changes during playback have no effect until the next `start`.
- Duration counter is DUR_W bits, unsigned, and never wraps below 1.

## Timing
- All outputs are registered.
- **Reset values** (`rst` low at an edge):
  - State = IDLE; `sel_out` = 3'b011; `gen_rst` = 1 for every cycle `rst` is low; `busy` = 0; `seg_idx` = 0; `done` = 0.
  - All slots = {3'b011, 1}; latched last = 0.
- `start` sampled at edge t:
  - `busy` = 1 and `gen_rst` = 1 from t+1.
  - First RUN cycle at t+2.
- A segment with duration d occupies exactly 1 + max(d, 1) cycles (LOAD + RUN).
- Non-looping playback of slots 0..L takes Σ(1 + max(dᵢ, 1)) cycles. `done` is high and `busy` is 0 in the cycle after the last RUN cycle.
- `stop` at edge t: `busy` = 0 and `sel_out` = `IDLE_SEL` at t+1.
- Reset mid-playback: IDLE next edge; the programme is cleared.

## Configuration
- `FGS_LOOP_EN` defined:
  - `loop` port exists and is sampled in the final RUN cycle of `last_idx`.
  - Loop high: wraps to slot 0 with no IDLE gap.
- `FGS_LOOP_EN` undefined:
  - No `loop` port.
  - Playback always ends after `last_idx` with a `done` pulse.

## Structure
- Package `func_gen_pkg`:
  - State enum `fgs_state_t` {IDLE, LOAD, RUN}.
  - `IDLE_SEL` = 3'b011.
  - Select-code constants: `SEL_SINE` = 0, `SEL_SQUARE` = 1, `SEL_COUNT` = 3.
  - Segment struct `{sel, dur}`.
- One sub-module, `fgs_seg_mem`: DEPTH×(3+DUR_W) register file with one synchronous write, one async read, and synchronous reset clear.

## Test plan
- **Reset:** hold `rst` low 3 cycles → `sel_out` = 3, `gen_rst` = 1, `busy` = 0, `seg_idx` = 0; after release, `gen_rst` = 0.
- **Two-slot play:** slot0 = {0, 4}, slot1 = {1, 2}, `last_idx` = 1, `start` at t → `gen_rst` high at t+1 and t+6; `sel_out` = 0 for t+1..t+5 and 1 for t+6..t+8; `done` at t+9; `busy` low at t+9.
- **Zero duration:** slot0 = {3, 0}, `last_idx` = 0, `start` → segment lasts 2 cycles; `done` 3 cycles after `start`.
- **Stop mid-RUN:** 4-slot programme, `stop` during slot 2 → IDLE next cycle, `sel_out` = 3, no `done`; a `wr_en` issued the same cycle as `stop` is ignored.
- **Loop (`FGS_LOOP_EN`):** `loop` = 1, `last_idx` = 1 → `seg_idx` sequence 0, 1, 0, 1 with no gap; drop `loop` → `done` after the next slot 1.
- **Simultaneous `start` and `stop` in IDLE** → stays IDLE, `busy` = 0; `start` while busy → ignored, playback timing unchanged.
